// File: rtl/accel_pkg.sv
// Shared definitions for the accel_seq_alu peripheral: opcodes, FSM states,
// register map addresses and STATUS bit positions.
package accel_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MUL = 4'd5
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam logic [3:0] ADDR_R0     = 4'h0;
  localparam logic [3:0] ADDR_SRC    = 4'h8;
  localparam logic [3:0] ADDR_DST    = 4'h9;
  localparam logic [3:0] ADDR_CMD    = 4'hA;
  localparam logic [3:0] ADDR_STATUS = 4'hB;
  localparam logic [3:0] ADDR_RES_LO = 4'hC;
  localparam logic [3:0] ADDR_RES_HI = 4'hD;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_ZERO  = 1;
  localparam int unsigned ST_CARRY = 2;
  localparam int unsigned ST_ERR   = 3;
  localparam int unsigned ST_OVR   = 4;
  localparam int unsigned ST_DONE  = 5;

endpackage

// File: rtl/accel_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle over DATA_W cycles.
module accel_mul_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] acc, mcand, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  // The final accumulation is presented combinationally alongside done so the
  // caller can register the product on the same edge as the last step.
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CNT_W'(DATA_W - 1));
  assign prod    = acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/accel_seq_alu.sv
// Memory-mapped arithmetic peripheral: operand register file, command FSM,
// single-cycle ALU, sequential multiplier, status flags and optional writeback.
module accel_seq_alu
  import accel_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  input  logic [3:0]        address,
  input  logic              data_write,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned SEL_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] src_q, dst_q, res_lo, res_hi, op_a, op_b;
  logic [3:0]        op_q;
  logic              wb_en_q;
  logic [SEL_W-1:0]  wb_sel_q, sel_a, sel_b;
  logic              done_q, ovr_q, err_q, carry_q, zero_q;
  state_e            state, state_nxt;

  logic              busy, reg_hit, cmd_wr, accept, finish;
  logic              mul_start, mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic [DATA_W-1:0] alu_lo, alu_hi;
  logic              alu_c, alu_err;
  logic              unused;

  assign sel_a     = src_q[SEL_W-1:0];
  assign sel_b     = src_q[4 +: SEL_W];
  assign busy      = (state == EXEC);
  assign reg_hit   = (32'(address) < NREGS);
  assign cmd_wr    = data_write && (address == ADDR_CMD);
  assign accept    = cmd_wr && (state == IDLE);
  assign mul_start = accept && (data_in[3:0] == OP_MUL);
  assign finish    = busy && ((op_q != OP_MUL) || mul_done);
  assign uo_out    = {5'b0, done_q, busy, 1'b0};
  assign unused    = ^{ui_in, src_q, dst_q, mul_busy};

  accel_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (regs[sel_a]),
    .b     (regs[sel_b]),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: {alu_c, alu_lo} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: begin
        alu_lo = op_a - op_b;
        alu_c  = (op_a < op_b);
      end
      OP_AND: alu_lo = op_a & op_b;
      OP_OR:  alu_lo = op_a | op_b;
      OP_XOR: alu_lo = op_a ^ op_b;
      OP_MUL: begin
        alu_lo = mul_prod[DATA_W-1:0];
        alu_hi = mul_prod[2*DATA_W-1:DATA_W];
        alu_c  = |alu_hi;
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      res_lo   <= '0;
      res_hi   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_q     <= '0;
      wb_en_q  <= 1'b0;
      wb_sel_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (data_write && address == ADDR_SRC) src_q <= data_in;
      if (data_write && address == ADDR_DST) dst_q <= data_in;
      if (cmd_wr && busy) ovr_q <= 1'b1;
      if (data_write && address == ADDR_STATUS) begin
        if (data_in[ST_DONE]) done_q <= 1'b0;
        if (data_in[ST_OVR])  ovr_q  <= 1'b0;
        if (data_in[ST_ERR])  err_q  <= 1'b0;
      end
      if (accept) begin
        op_q     <= data_in[3:0];
        op_a     <= regs[sel_a];
        op_b     <= regs[sel_b];
        wb_en_q  <= dst_q[7];
        wb_sel_q <= dst_q[SEL_W-1:0];
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        carry_q  <= 1'b0;
        zero_q   <= 1'b0;
      end
      if (finish) begin
        res_lo  <= alu_lo;
        res_hi  <= alu_hi;
        carry_q <= alu_c;
        zero_q  <= (alu_lo == '0);
        err_q   <= alu_err;
        done_q  <= 1'b1;
        if (wb_en_q) regs[wb_sel_q] <= alu_lo;
      end
      // Bus write is applied after writeback so it takes priority on a clash.
      if (data_write && reg_hit) regs[address[SEL_W-1:0]] <= data_in;
    end
  end

  always_comb begin
    data_out = '0;
    if (reg_hit) begin
      data_out = regs[address[SEL_W-1:0]];
    end else begin
      case (address)
        ADDR_SRC:    data_out = src_q;
        ADDR_DST:    data_out = dst_q;
        ADDR_CMD:    data_out = DATA_W'(op_q);
        ADDR_STATUS: data_out = DATA_W'({done_q, ovr_q, err_q, carry_q, zero_q, busy});
        ADDR_RES_LO: data_out = res_lo;
        ADDR_RES_HI: data_out = res_hi;
        default:     data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_seq_alu.sv
// Directed bench for accel_seq_alu: 8-bit/4-reg instance plus a 16-bit/8-reg instance.
module tb_accel_seq_alu;
  import accel_pkg::*;

  logic        clk, rst_n, dw8, dw16;
  logic [3:0]  address;
  logic [15:0] wdata;
  logic [7:0]  ui_in, uo8, uo16, dout8;
  logic [15:0] dout16;
  logic [15:0] v;
  int          n_checks, n_errors, lat;

  accel_seq_alu #(.DATA_W(8), .NREGS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo8), .address(address),
    .data_write(dw8), .data_in(wdata[7:0]), .data_out(dout8)
  );

  accel_seq_alu #(.DATA_W(16), .NREGS(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16), .address(address),
    .data_write(dw16), .data_in(wdata), .data_out(dout16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, lo, hi, st;
    int         lat;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write lands on the next clock edge; returns 1 ns into the following cycle.
  task automatic bus_wr(input bit big, input logic [3:0] a, input logic [15:0] d);
    address = a;
    wdata   = d;
    if (big) dw16 = 1'b1; else dw8 = 1'b1;
    step();
    dw8  = 1'b0;
    dw16 = 1'b0;
  endtask

  task automatic rd(input bit big, input logic [3:0] a, output logic [15:0] val);
    address = a;
    #1;
    val = big ? dout16 : {8'h00, dout8};
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input bit big, output int cycles);
    cycles = 0;
    while (((big ? uo16[2] : uo8[2]) !== 1'b1) && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0; dw8 = 1'b0; dw16 = 1'b0; address = '0; wdata = '0; ui_in = '0;
    n_checks = 0; n_errors = 0;

    //         op     a      b      lo     hi     status lat
    vecs[0]  = '{4'd0, 8'hF0, 8'h20, 8'h10, 8'h00, 8'h24, 1};
    vecs[1]  = '{4'd0, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h26, 1};
    vecs[2]  = '{4'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 8'h24, 1};
    vecs[3]  = '{4'd1, 8'h07, 8'h07, 8'h00, 8'h00, 8'h22, 1};
    vecs[4]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 8'h20, 1};
    vecs[5]  = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h20, 1};
    vecs[6]  = '{4'd4, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h22, 1};
    vecs[7]  = '{4'd5, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h24, 8};
    vecs[8]  = '{4'd5, 8'h10, 8'h0F, 8'hF0, 8'h00, 8'h20, 8};
    vecs[9]  = '{4'd5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h22, 8};
    vecs[10] = '{4'd9, 8'h12, 8'h34, 8'h00, 8'h00, 8'h2A, 1};
    vecs[11] = '{4'hF, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h2A, 1};

    step(); step();
    rst_n = 1'b1;
    step();

    chk("reset_uo8", {8'h00, uo8}, 16'h0000);
    rd(0, ADDR_STATUS, v); chk("reset_status", v, 16'h0000);
    rd(0, ADDR_R0, v);     chk("reset_r0", v, 16'h0000);
    rd(0, ADDR_RES_LO, v); chk("reset_res_lo", v, 16'h0000);
    rd(0, 4'hE, v);        chk("unmapped_read", v, 16'h0000);

    // Test 1 with exact cycle timing
    bus_wr(0, ADDR_R0, 16'h00F0);
    bus_wr(0, 4'h1, 16'h0020);
    bus_wr(0, ADDR_SRC, 16'h0010);
    bus_wr(0, ADDR_CMD, 16'h0000);
    chk("t1_busy_n1", {8'h00, uo8}, 16'h0002);
    step();
    chk("t1_uo_n2", {8'h00, uo8}, 16'h0004);
    rd(0, ADDR_RES_LO, v); chk("t1_res_lo", v, 16'h0010);
    rd(0, ADDR_STATUS, v); chk("t1_status", v, 16'h0024);

    // Table-driven ops
    for (int i = 0; i < 12; i++) begin
      step();
      bus_wr(0, ADDR_R0, {8'h00, vecs[i].a});
      bus_wr(0, 4'h1, {8'h00, vecs[i].b});
      bus_wr(0, ADDR_SRC, 16'h0010);
      bus_wr(0, ADDR_DST, 16'h0000);
      bus_wr(0, ADDR_CMD, {12'h000, vecs[i].op});
      wait_done(0, lat);
      chk($sformatf("vec%0d_latency", i), 16'(lat), 16'(vecs[i].lat));
      rd(0, ADDR_RES_LO, v); chk($sformatf("vec%0d_res_lo", i), v, {8'h00, vecs[i].lo});
      rd(0, ADDR_RES_HI, v); chk($sformatf("vec%0d_res_hi", i), v, {8'h00, vecs[i].hi});
      rd(0, ADDR_STATUS, v); chk($sformatf("vec%0d_status", i), v, {8'h00, vecs[i].st});
    end

    // Test 2: SUB with writeback to R1
    step();
    bus_wr(0, 4'h2, 16'h0005);
    bus_wr(0, 4'h3, 16'h0007);
    bus_wr(0, ADDR_SRC, 16'h0032);
    bus_wr(0, ADDR_DST, 16'h0081);
    bus_wr(0, ADDR_CMD, 16'h0001);
    wait_done(0, lat);
    rd(0, ADDR_RES_LO, v); chk("t2_res_lo", v, 16'h00FE);
    rd(0, ADDR_STATUS, v); chk("t2_status", v, 16'h0024);
    rd(0, 4'h1, v);        chk("t2_wb_r1", v, 16'h00FE);

    // Test 3: MUL with a colliding CMD at N+3
    bus_wr(0, ADDR_R0, 16'h00FF);
    bus_wr(0, 4'h1, 16'h00FF);
    bus_wr(0, ADDR_SRC, 16'h0010);
    bus_wr(0, ADDR_DST, 16'h0000);
    bus_wr(0, ADDR_CMD, 16'h0005);
    step(); step();
    bus_wr(0, ADDR_CMD, 16'h0000);
    chk("t3_busy_n4", {8'h00, uo8}, 16'h0002);
    step(); step(); step(); step();
    chk("t3_busy_n8", {8'h00, uo8}, 16'h0002);
    step();
    chk("t3_done_n9", {8'h00, uo8}, 16'h0004);
    rd(0, ADDR_STATUS, v); chk("t3_status_ovr", v, 16'h0034);
    rd(0, ADDR_RES_HI, v); chk("t3_res_hi", v, 16'h00FE);
    rd(0, ADDR_RES_LO, v); chk("t3_res_lo", v, 16'h0001);
    bus_wr(0, ADDR_STATUS, 16'h0030);
    step();
    rd(0, ADDR_STATUS, v); chk("t3_status_w1c", v, 16'h0004);

    // Test 4: XOR of R0 with itself
    bus_wr(0, ADDR_R0, 16'h003C);
    bus_wr(0, ADDR_SRC, 16'h0000);
    bus_wr(0, ADDR_CMD, 16'h0004);
    wait_done(0, lat);
    rd(0, ADDR_RES_LO, v); chk("t4_res_lo", v, 16'h0000);
    rd(0, ADDR_STATUS, v); chk("t4_status", v, 16'h0022);

    // Test 5a: bus write to R1 in the writeback cycle wins
    bus_wr(0, ADDR_R0, 16'h0003);
    bus_wr(0, 4'h1, 16'h0004);
    bus_wr(0, ADDR_SRC, 16'h0010);
    bus_wr(0, ADDR_DST, 16'h0081);
    bus_wr(0, ADDR_CMD, 16'h0000);
    bus_wr(0, 4'h1, 16'h0055);
    rd(0, ADDR_RES_LO, v); chk("t5_res_lo", v, 16'h0007);
    rd(0, 4'h1, v);        chk("t5_bus_wins", v, 16'h0055);

    // Test 5b: reset in the middle of a MUL
    bus_wr(0, ADDR_R0, 16'h0012);
    bus_wr(0, 4'h1, 16'h0034);
    bus_wr(0, ADDR_DST, 16'h0082);
    bus_wr(0, ADDR_CMD, 16'h0005);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("t5_rst_uo", {8'h00, uo8}, 16'h0000);
    rst_n = 1'b1;
    rd(0, ADDR_R0, v);     chk("t5_rst_r0", v, 16'h0000);
    rd(0, ADDR_SRC, v);    chk("t5_rst_src", v, 16'h0000);
    rd(0, ADDR_DST, v);    chk("t5_rst_dst", v, 16'h0000);
    for (int i = 0; i < 10; i++) step();
    rd(0, 4'h2, v);        chk("t5_no_wb", v, 16'h0000);
    rd(0, ADDR_STATUS, v); chk("t5_rst_status", v, 16'h0000);

    // Test 6: 16-bit, 8-register instance
    bus_wr(1, 4'h7, 16'h1234);
    bus_wr(1, 4'h6, 16'h0100);
    bus_wr(1, ADDR_SRC, 16'h0067);
    bus_wr(1, ADDR_CMD, 16'h0005);
    for (int i = 0; i < 15; i++) step();
    chk("t6_busy_n16", {8'h00, uo16}, 16'h0002);
    step();
    chk("t6_done_n17", {8'h00, uo16}, 16'h0004);
    rd(1, ADDR_RES_HI, v); chk("t6_res_hi", v, 16'h0012);
    rd(1, ADDR_RES_LO, v); chk("t6_res_lo", v, 16'h3400);
    rd(1, ADDR_STATUS, v); chk("t6_status", v, 16'h0024);
    rd(1, 4'h7, v);        chk("t6_r7", v, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
